// File: rtl/hold_led_if.sv
// Indicator bus for the hold_led driver: carries the single LED line.
interface hold_led_if;
   logic LED;

   // Driver side owns the LED line.
   modport master (output LED);
   // Consumer side only observes it.
   modport slave  (input  LED);
endinterface

// File: rtl/hold_led.sv
// Timed indicator driver: after each reset release, LED is high for exactly
// `cycle` clock periods, then stays low until the next reset assertion.
module hold_led #(
   parameter int unsigned cycle = 250
) (
   input  logic       clk,
   input  logic       reset,
   hold_led_if.master bus
);

   localparam int unsigned CntW = $clog2(cycle + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(cycle - 1);

   typedef enum logic [1:0] {
      StArm  = 2'd0,
      StHold = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            led_q, led_d;

   // State, counter and LED flops; reset clears all of them without a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StArm;
         cnt_q   <= '0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
      end
   end

   // Next-state logic: ARM starts the window, HOLD counts it out, DONE parks.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      led_d   = led_q;
      case (state_q)
         StArm: begin
            state_d = StHold;
            cnt_d   = '0;
            led_d   = 1'b1;
         end
         StHold: begin
            if (cnt_q == CntLast) begin
               state_d = StDone;
               cnt_d   = '0;
               led_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
               led_d = 1'b1;
            end
         end
         StDone: begin
            cnt_d = '0;
            led_d = 1'b0;
         end
         // Unused encoding: park safely with the indicator off.
         default: begin
            state_d = StDone;
            cnt_d   = '0;
            led_d   = 1'b0;
         end
      endcase
   end

   // LED is taken straight from its flop.
   assign bus.LED = led_q;

endmodule

// File: tb/tb_hold_led.sv
// Self-checking bench for hold_led with cycle = 250, 1 and 4.
module tb_hold_led;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1;  // cycle = 250
   logic rst_b = 1'b1;  // cycle = 1
   logic rst_c = 1'b1;  // cycle = 4

   hold_led_if if_a ();
   hold_led_if if_b ();
   hold_led_if if_c ();

   hold_led #(.cycle(250)) u_a (.clk(clk), .reset(rst_a), .bus(if_a.master));
   hold_led #(.cycle(1))   u_b (.clk(clk), .reset(rst_b), .bus(if_b.master));
   hold_led #(.cycle(4))   u_c (.clk(clk), .reset(rst_c), .bus(if_c.master));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: LED got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic rst;
      logic led;
   } vec_t;

   vec_t vecs[16];

   int   n;      // reference model: edges sampled with reset high since last assertion
   int   run;
   logic r;
   logic exp;

   initial begin
      // Table for cycle = 4: reset applied before an edge, LED expected after it.
      vecs[0]  = '{1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1};
      vecs[2]  = '{1'b1, 1'b1};
      vecs[3]  = '{1'b1, 1'b1};
      vecs[4]  = '{1'b1, 1'b1};
      vecs[5]  = '{1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1};
      vecs[9]  = '{1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1};
      vecs[12] = '{1'b1, 1'b1};
      vecs[13] = '{1'b1, 1'b1};
      vecs[14] = '{1'b1, 1'b1};
      vecs[15] = '{1'b1, 1'b0};

      // Reset before any clock edge.
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      #1;
      check("pre_edge_a", if_a.LED, 1'b0);
      check("pre_edge_b", if_b.LED, 1'b0);
      check("pre_edge_c", if_c.LED, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("in_reset_a", if_a.LED, 1'b0);
         check("in_reset_b", if_b.LED, 1'b0);
         check("in_reset_c", if_c.LED, 1'b0);
      end

      // cycle = 1: exactly one high clock.
      @(negedge clk);
      rst_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check("cycle1_window", if_b.LED, (i == 0));
      end

      // cycle = 250: full window then 1000 more cycles without restart.
      @(negedge clk);
      rst_a = 1'b1;
      for (int i = 0; i < 1250; i++) begin
         @(posedge clk);
         #1;
         check("c250_window", if_a.LED, (i < 250));
      end

      // Reset during DONE, then a fresh window interrupted at edge E+100.
      @(negedge clk);
      rst_a = 1'b0;
      #1;
      check("c250_done_reset", if_a.LED, 1'b0);
      @(negedge clk);
      rst_a = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         @(posedge clk);
         #1;
         check("c250_second_window", if_a.LED, 1'b1);
      end
      #1;
      rst_a = 1'b0;
      #1;
      check("c250_async_drop", if_a.LED, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("c250_held_reset", if_a.LED, 1'b0);
      end
      @(negedge clk);
      rst_a = 1'b1;
      for (int i = 0; i < 260; i++) begin
         @(posedge clk);
         #1;
         check("c250_restart_window", if_a.LED, (i < 250));
      end

      // cycle = 4: table-driven vectors.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rst_c = vecs[i].rst;
         @(posedge clk);
         #1;
         check($sformatf("vec[%0d]", i), if_c.LED, vecs[i].led);
      end

      // cycle = 4: random reset every edge against the edge-count model.
      @(negedge clk);
      rst_c = 1'b0;
      n     = 0;
      run   = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         r     = ($urandom_range(0, 3) != 0);
         rst_c = r;
         if (!r) begin
            n = 0;
            #1;
            check("rand_async_clear", if_c.LED, 1'b0);
         end
         @(posedge clk);
         if (rst_c && n < 1000) n++;
         #1;
         exp = (n >= 1) && (n <= 4);
         check("rand_model", if_c.LED, exp);
         run = if_c.LED ? run + 1 : 0;
         check("rand_max_run", (run <= 4), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
